// File: rtl/difficulty_scheduler_pkg.sv
// rtl/difficulty_scheduler_pkg.sv - shared types and constants for the difficulty scheduler
// Purpose: FSM state encoding, widths, default requester count, and the
//          share/mask test used to produce res_hit.
package difficulty_scheduler_pkg;

  localparam int DIFF_IDX_W     = 4;
  localparam int MASK_W         = 16;
  localparam int N_REQ_DEFAULT  = 4;
  localparam int HASH_W_DEFAULT = 16;
  // Requester index width; sized for the largest supported N_REQ (8).
  localparam int ID_W           = 3;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // A share meets the difficulty when no masked bit of its MSB word is set.
  function automatic logic share_hit(input logic [MASK_W-1:0] word,
                                     input logic [MASK_W-1:0] mask);
    return (word & mask) == '0;
  endfunction

endpackage

// File: rtl/difficulty_scheduler_if.sv
// rtl/difficulty_scheduler_if.sv - config, map, share and result signals of the scheduler
// Purpose: groups every non-clock/reset signal of difficulty_scheduler.
// Signals:
//   cfg_we, cfg_index         difficulty index load strobe and value
//   map_en, map_addr          read request to the external difficulty map
//   map_difficulty            map read data, one cycle after map_en
//   req, hash                 per-requester share request and hash MSBs
//   ack                       one-hot grant
//   ready                     mask loaded, arbitration enabled
//   res_valid, res_hit, res_id  one-cycle result of the last granted share
// Modports: slave = the scheduler, master = the surrounding logic.
interface difficulty_scheduler_if
  import difficulty_scheduler_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int HASH_W = HASH_W_DEFAULT
);

  logic                    cfg_we;
  logic [DIFF_IDX_W-1:0]   cfg_index;
  logic                    map_en;
  logic [DIFF_IDX_W-1:0]   map_addr;
  logic [MASK_W-1:0]       map_difficulty;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*HASH_W-1:0] hash;
  logic [N_REQ-1:0]        ack;
  logic                    ready;
  logic                    res_valid;
  logic                    res_hit;
  logic [ID_W-1:0]         res_id;

  modport slave (
    input  cfg_we, cfg_index, map_difficulty, req, hash,
    output map_en, map_addr, ack, ready, res_valid, res_hit, res_id
  );

  modport master (
    output cfg_we, cfg_index, map_difficulty, req, hash,
    input  map_en, map_addr, ack, ready, res_valid, res_hit, res_id
  );

endinterface

// File: rtl/difficulty_scheduler_rr_arbiter.sv
// rtl/difficulty_scheduler_rr_arbiter.sv - round-robin requester selection
// Purpose: picks the first set request after last_grant, wrapping mod N_REQ.
// Ports:
//   req_i         per-requester request
//   last_grant_i  index of the previously granted requester
//   grant_o       one-hot grant (zero when no request)
//   grant_idx_o   index of the granted requester (zero when no request)
module rr_arbiter
  import difficulty_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o
);

  int   idx;
  logic found;

  // Offsets 1..N_REQ visit every requester once, the last one being
  // last_grant itself, so a lone requester can be granted repeatedly.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/difficulty_scheduler.sv
// rtl/difficulty_scheduler.sv - loads a difficulty mask and checks round-robin shares against it
// Purpose: reads the mask for the configured index from the external map,
//          then grants one share request per cycle and reports whether its
//          hash MSBs clear the mask, one cycle after the grant.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    difficulty_scheduler_if.slave (config, map, shares, results)
module difficulty_scheduler
  import difficulty_scheduler_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int HASH_W = HASH_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  difficulty_scheduler_if.slave   bus
);

  state_e                state_q;
  logic [DIFF_IDX_W-1:0] index_q;
  logic [MASK_W-1:0]     mask_q;
  logic [ID_W-1:0]       last_grant_q;
  logic                  res_valid_q;
  logic                  res_hit_q;
  logic [ID_W-1:0]       res_id_q;

  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_en;
  logic [N_REQ-1:0]      ack_w;
  logic                  ack_fire;
  logic [HASH_W-1:0]     sel_hash;
  logic [MASK_W-1:0]     cmp_word;
  logic                  hit_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i        (bus.req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // A config write wins over a grant in the same cycle.
  assign grant_en = (state_q == ST_RUN) && !bus.cfg_we;
  assign ack_w    = grant_en ? grant : '0;
  assign ack_fire = |ack_w;

  always_comb begin
    sel_hash = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_hash = bus.hash[i*HASH_W +: HASH_W];
    end
  end

  // Narrow hashes are top-aligned and zero-padded so only the top HASH_W
  // mask bits can ever reject a share.
  if (HASH_W >= MASK_W) begin : g_wide
    assign cmp_word = sel_hash[HASH_W-1 -: MASK_W];
  end else begin : g_narrow
    assign cmp_word = {sel_hash, {(MASK_W-HASH_W){1'b0}}};
  end

  assign hit_d = share_hit(cmp_word, mask_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      index_q      <= '0;
      mask_q       <= '0;
      last_grant_q <= '0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_id_q     <= '0;
    end else begin
      // Result path is independent of config, so a share granted just
      // before a reload still reports against the mask of its grant cycle.
      res_valid_q <= ack_fire;
      if (ack_fire) begin
        res_id_q     <= grant_idx;
        res_hit_q    <= hit_d;
        last_grant_q <= grant_idx;
      end

      if (bus.cfg_we) begin
        // Restarting from LOAD skips any pending capture of the old index.
        index_q <= bus.cfg_index;
        state_q <= ST_LOAD;
      end else begin
        case (state_q)
          ST_LOAD:    state_q <= ST_CAPTURE;
          ST_CAPTURE: begin
            mask_q  <= bus.map_difficulty;
            state_q <= ST_RUN;
          end
          ST_RUN:     state_q <= ST_RUN;
          default:    state_q <= ST_LOAD;
        endcase
      end
    end
  end

  assign bus.map_en    = (state_q == ST_LOAD);
  assign bus.map_addr  = index_q;
  assign bus.ready     = (state_q == ST_RUN);
  assign bus.ack       = ack_w;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_difficulty_scheduler.sv
// tb/tb_difficulty_scheduler.sv - directed self-checking bench for difficulty_scheduler
module tb_difficulty_scheduler;

  localparam int NR = 4;
  localparam int HW = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  difficulty_scheduler_if #(.N_REQ(NR), .HASH_W(HW)) bus ();

  difficulty_scheduler #(.N_REQ(NR), .HASH_W(HW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [15:0] rom(input logic [3:0] a);
    case (a)
      4'd0:    return 16'h0000;
      4'd4:    return 16'hF000;
      4'd7:    return 16'h00FF;
      4'd15:   return 16'hFFFE;
      default: return 16'h5A5A;
    endcase
  endfunction

  // External difficulty map: synchronous read, data one cycle after map_en.
  initial bus.map_difficulty = 16'h0000;
  always @(posedge clk) if (bus.map_en) bus.map_difficulty <= rom(bus.map_addr);

  task automatic test_reset();
    reset = 1'b1; bus.cfg_we = 1'b0; bus.cfg_index = 4'd0; bus.req = '0; bus.hash = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if ({bus.ready, bus.ack, bus.res_valid, bus.res_hit, bus.res_id, bus.map_en, bus.map_addr} !== 15'b0_0000_0_0_000_1_0000) begin
      bad++; $display("FAIL reset_state: got %b want %b", {bus.ready, bus.ack, bus.res_valid, bus.res_hit, bus.res_id, bus.map_en, bus.map_addr}, 15'b0_0000_0_0_000_1_0000); end
    @(negedge clk); reset = 1'b0; #1;
    total++; if ({bus.map_en, bus.map_addr, bus.ready} !== 6'b1_0000_0) begin
      bad++; $display("FAIL first_load: got %b want %b", {bus.map_en, bus.map_addr, bus.ready}, 6'b1_0000_0); end
    @(negedge clk); #1;
    total++; if ({bus.map_en, bus.ready} !== 2'b00) begin
      bad++; $display("FAIL first_capture: got %b want 00", {bus.map_en, bus.ready}); end
    @(negedge clk); #1;
    total++; if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL ready_third_cycle: got %b want 1", bus.ready); end
  endtask

  task automatic test_mask0();
    @(negedge clk); bus.req = 4'b0001; bus.hash[15:0] = 16'hFFFF; #1;
    total++; if (bus.ack !== 4'b0001) begin
      bad++; $display("FAIL mask0_ack: got %b want 0001", bus.ack); end
    @(negedge clk); bus.req = 4'b0000; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id, bus.ack} !== 9'b1_1_000_0000) begin
      bad++; $display("FAIL mask0_result: got %b want %b", {bus.res_valid, bus.res_hit, bus.res_id, bus.ack}, 9'b1_1_000_0000); end
    @(negedge clk); #1;
    total++; if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL mask0_pulse_end: got %b want 0", bus.res_valid); end
  endtask

  task automatic test_cfg_hit();
    @(negedge clk); bus.cfg_we = 1'b1; bus.cfg_index = 4'd4; #1;
    total++; if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL cfg4_ready_before: got %b want 1", bus.ready); end
    @(negedge clk); bus.cfg_we = 1'b0; #1;
    total++; if ({bus.map_en, bus.map_addr, bus.ready} !== 6'b1_0100_0) begin
      bad++; $display("FAIL cfg4_load: got %b want %b", {bus.map_en, bus.map_addr, bus.ready}, 6'b1_0100_0); end
    @(negedge clk); #1;
    total++; if ({bus.map_en, bus.ready} !== 2'b00) begin
      bad++; $display("FAIL cfg4_capture: got %b want 00", {bus.map_en, bus.ready}); end
    @(negedge clk); bus.req = 4'b0010; bus.hash[31:16] = 16'h0FFF; #1;
    total++; if ({bus.ready, bus.ack} !== 5'b1_0010) begin
      bad++; $display("FAIL cfg4_ack_a: got %b want 10010", {bus.ready, bus.ack}); end
    @(negedge clk); bus.hash[31:16] = 16'h1000; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id, bus.ack} !== 9'b1_1_001_0010) begin
      bad++; $display("FAIL cfg4_hit_0fff: got %b want %b", {bus.res_valid, bus.res_hit, bus.res_id, bus.ack}, 9'b1_1_001_0010); end
    @(negedge clk); bus.req = 4'b0000; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id} !== 5'b1_0_001) begin
      bad++; $display("FAIL cfg4_miss_1000: got %b want 10001", {bus.res_valid, bus.res_hit, bus.res_id}); end
    @(negedge clk); #1;
    total++; if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL cfg4_pulse_end: got %b want 0", bus.res_valid); end
  endtask

  task automatic test_back_to_back();
    int         exp_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [3:0] hitv = 4'b0101;
    int         prev = 0;
    bus.hash = {16'h8000, 16'h0FFF, 16'hF000, 16'h0000};
    @(negedge clk); bus.req = 4'b0001; #1;
    total++; if (bus.ack !== 4'b0001) begin
      bad++; $display("FAIL rr_prime: got %b want 0001", bus.ack); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); bus.req = 4'b1111; #1;
      total++; if (bus.ack !== 4'(1 << exp_order[k])) begin
        bad++; $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.ack, 4'(1 << exp_order[k])); end
      total++; if ({bus.res_valid, bus.res_hit, bus.res_id} !== {1'b1, hitv[prev], 3'(prev)}) begin
        bad++; $display("FAIL rr_result[%0d]: got %b want %b", k, {bus.res_valid, bus.res_hit, bus.res_id}, {1'b1, hitv[prev], 3'(prev)}); end
      prev = exp_order[k];
    end
    @(negedge clk); bus.req = 4'b0000; #1;
    total++; if ({bus.ack, bus.res_valid, bus.res_hit, bus.res_id} !== 9'b0000_1_1_000) begin
      bad++; $display("FAIL rr_last_result: got %b want %b", {bus.ack, bus.res_valid, bus.res_hit, bus.res_id}, 9'b0000_1_1_000); end
    @(negedge clk); #1;
    total++; if ({bus.ack, bus.res_valid} !== 5'b0000_0) begin
      bad++; $display("FAIL rr_idle: got %b want 00000", {bus.ack, bus.res_valid}); end
  endtask

  task automatic test_cfg_priority();
    @(negedge clk); bus.cfg_we = 1'b1; bus.cfg_index = 4'd7; bus.req = 4'b0100; bus.hash[47:32] = 16'h0001; #1;
    total++; if ({bus.ready, bus.ack} !== 5'b1_0000) begin
      bad++; $display("FAIL prio_no_ack: got %b want 10000", {bus.ready, bus.ack}); end
    @(negedge clk); bus.cfg_we = 1'b0; #1;
    total++; if ({bus.ready, bus.ack, bus.res_valid} !== 6'b0_0000_0) begin
      bad++; $display("FAIL prio_load: got %b want 000000", {bus.ready, bus.ack, bus.res_valid}); end
    @(negedge clk); #1;
    total++; if ({bus.ready, bus.ack} !== 5'b0_0000) begin
      bad++; $display("FAIL prio_capture: got %b want 00000", {bus.ready, bus.ack}); end
    @(negedge clk); #1;
    total++; if ({bus.ready, bus.ack} !== 5'b1_0100) begin
      bad++; $display("FAIL prio_grant: got %b want 10100", {bus.ready, bus.ack}); end
    @(negedge clk); bus.req = 4'b0000; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id} !== 5'b1_0_010) begin
      bad++; $display("FAIL prio_new_mask: got %b want 10010", {bus.res_valid, bus.res_hit, bus.res_id}); end
  endtask

  task automatic test_ack_before_cfg();
    @(negedge clk); bus.req = 4'b1000; bus.hash[63:48] = 16'hF000; #1;
    total++; if (bus.ack !== 4'b1000) begin
      bad++; $display("FAIL late_ack: got %b want 1000", bus.ack); end
    @(negedge clk); bus.req = 4'b0000; bus.cfg_we = 1'b1; bus.cfg_index = 4'd4; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id} !== 5'b1_1_011) begin
      bad++; $display("FAIL late_old_mask: got %b want 11011", {bus.res_valid, bus.res_hit, bus.res_id}); end
    @(negedge clk); bus.cfg_we = 1'b0; #1;
    total++; if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL late_pulse_end: got %b want 0", bus.res_valid); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_restart_capture();
    @(negedge clk); bus.cfg_we = 1'b1; bus.cfg_index = 4'd4;
    @(negedge clk); bus.cfg_we = 1'b0;
    @(negedge clk); bus.cfg_we = 1'b1; bus.cfg_index = 4'd15; #1;
    total++; if ({bus.map_en, bus.ready} !== 2'b00) begin
      bad++; $display("FAIL restart_in_capture: got %b want 00", {bus.map_en, bus.ready}); end
    @(negedge clk); bus.cfg_we = 1'b0; #1;
    total++; if ({bus.map_en, bus.map_addr, bus.ready} !== 6'b1_1111_0) begin
      bad++; $display("FAIL restart_load: got %b want %b", {bus.map_en, bus.map_addr, bus.ready}, 6'b1_1111_0); end
    @(negedge clk); #1;
    @(negedge clk); bus.req = 4'b0001; bus.hash[15:0] = 16'h0001; #1;
    total++; if ({bus.ready, bus.ack} !== 5'b1_0001) begin
      bad++; $display("FAIL restart_grant: got %b want 10001", {bus.ready, bus.ack}); end
    @(negedge clk); bus.hash[15:0] = 16'h0002; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id, bus.ack} !== 9'b1_1_000_0001) begin
      bad++; $display("FAIL restart_hit_0001: got %b want %b", {bus.res_valid, bus.res_hit, bus.res_id, bus.ack}, 9'b1_1_000_0001); end
    @(negedge clk); bus.req = 4'b0000; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id} !== 5'b1_0_000) begin
      bad++; $display("FAIL restart_miss_0002: got %b want 10000", {bus.res_valid, bus.res_hit, bus.res_id}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus.req = 4'b0010; bus.hash[31:16] = 16'h0001; #1;
    total++; if (bus.ack !== 4'b0010) begin
      bad++; $display("FAIL rst_mid_ack: got %b want 0010", bus.ack); end
    @(negedge clk); reset = 1'b1; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id, bus.ack, bus.ready, bus.map_en, bus.map_addr} !== 15'b0_0_000_0000_0_1_0000) begin
      bad++; $display("FAIL rst_mid_async: got %b want %b", {bus.res_valid, bus.res_hit, bus.res_id, bus.ack, bus.ready, bus.map_en, bus.map_addr}, 15'b0_0_000_0000_0_1_0000); end
    @(negedge clk); #1;
    total++; if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_held: got %b want 0", bus.res_valid); end
    @(negedge clk); reset = 1'b0; bus.req = 4'b0000; #1;
    total++; if ({bus.res_valid, bus.map_en, bus.map_addr, bus.ready} !== 7'b0_1_0000_0) begin
      bad++; $display("FAIL rst_mid_reload: got %b want %b", {bus.res_valid, bus.map_en, bus.map_addr, bus.ready}, 7'b0_1_0000_0); end
    @(negedge clk); #1;
    total++; if ({bus.res_valid, bus.ready} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_capture: got %b want 00", {bus.res_valid, bus.ready}); end
    @(negedge clk); bus.req = 4'b0101; bus.hash[15:0] = 16'hFFFF; bus.hash[47:32] = 16'hFFFF; #1;
    total++; if ({bus.ready, bus.ack} !== 5'b1_0100) begin
      bad++; $display("FAIL rst_mid_rr_restart: got %b want 10100", {bus.ready, bus.ack}); end
    @(negedge clk); bus.req = 4'b0000; #1;
    total++; if ({bus.res_valid, bus.res_hit, bus.res_id} !== 5'b1_1_010) begin
      bad++; $display("FAIL rst_mid_mask0: got %b want 11010", {bus.res_valid, bus.res_hit, bus.res_id}); end
  endtask

  initial begin
    test_reset();
    test_mask0();
    test_cfg_hit();
    test_back_to_back();
    test_cfg_priority();
    test_ack_before_cfg();
    test_restart_capture();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
